// File: rtl/fetch_buffer_pkg.sv
// Shared processor defaults for the instruction fetch queue.
package fetch_buffer_pkg;

  localparam int unsigned FB_DEPTH   = 4;
  localparam int unsigned FB_PCW     = 8;
  localparam int unsigned FB_IW      = 32;
  localparam int unsigned FB_ENTRY_W = FB_IW + FB_PCW;

endpackage

// File: rtl/fetch_fifo.sv
// Circular entry store for the fetch queue; flush empties it in one cycle.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH,
  parameter int unsigned W     = FB_ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic                   valid,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_pop;

  always_comb begin
    valid  = (count != '0);
    do_pop = pop & valid;
    rdata  = valid ? mem[head] : '0;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)   tail <= tail + AW'(1);
      if (do_pop) head <= head + AW'(1);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= wdata;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: issues reads to a synchronous memory and buffers returns.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH,
  parameter int unsigned PCW   = FB_PCW,
  parameter int unsigned IW    = FB_IW
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PCW-1:0]         imAddress,
  input  logic [IW-1:0]          imData,
  input  logic                   redirect,
  input  logic [PCW-1:0]         redirectTarget,
  input  logic                   outReady,
  output logic                   outValid,
  output logic [IW-1:0]          outInstruction,
  output logic [PCW-1:0]         outPCPlus1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = IW + PCW;

  logic [PCW-1:0] fetch_pc;
  logic [PCW-1:0] in_flight_pc;
  logic           in_flight;
  logic           issue;
  logic [OW-1:0]  occupancy;
  logic [EW-1:0]  head_entry;

  // Same-cycle pops are not credited, so the queue can never overflow.
  always_comb begin
    imAddress = redirect ? redirectTarget : fetch_pc;
    occupancy = OW'(count) + OW'(in_flight);
    issue     = redirect | (occupancy < OW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= '0;
      in_flight    <= 1'b0;
      in_flight_pc <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        in_flight_pc <= imAddress;
        fetch_pc     <= imAddress + PCW'(1);
      end
    end
  end

  // A redirect drops the word returning this cycle along with the queue.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (in_flight & ~redirect),
    .wdata ({imData, in_flight_pc + PCW'(1)}),
    .pop   (outReady),
    .valid (outValid),
    .rdata (head_entry),
    .count (count)
  );

  assign outInstruction = head_entry[EW-1:PCW];
  assign outPCPlus1     = head_entry[PCW-1:0];

endmodule
